// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared definitions for the instruction-fetch block: bus
//               widths, ROM chip-enable levels, the zero instruction word,
//               fetch stride/alignment and the fetch FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;   // PC / ROM byte-address width
  localparam int InstBus     = 64;   // instruction width

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroDoubleWord = '0;

  // One instruction occupies 8 bytes, so fetch addresses are 8-byte aligned.
  localparam int InstByteStride = 8;
  localparam int InstAlignBits  = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO holding fetched {pc, instruction}
//               entries. Flush has priority over push and pop. A push into a
//               full FIFO is accepted only when a pop happens in the same
//               cycle.
// Ports       : clk, rst (sync, active-low)
//               push_i/push_data_i : write request and data
//               pop_i              : remove head entry
//               flush_i            : discard all entries
//               full_o/empty_o     : occupancy flags
//               head_o             : data at the head (registered storage)
//               count_o            : number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DATA_W-1:0]            head_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Fetch-side initiator for a combinational instruction ROM.
//               Holds the PC, enables the ROM whenever the fetch buffer can
//               accept an entry, buffers {pc, inst} pairs and presents them
//               to decode over valid/ready. Branch redirects flush the buffer
//               and reload the PC.
// Ports       : clk, rst (sync, active-low)
//               rom_ce/rom_addr/rom_inst         : ROM interface
//               branch_flag_i/branch_target_i    : redirect from EX
//               id_valid_o/id_ready_i            : decode handshake
//               id_pc_o/id_inst_o                : head entry to decode
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W     = InstAddrBus,
  parameter int                INST_W     = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam int ENTRY_W = ADDR_W + INST_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << InstAlignBits) - 1);
  localparam logic [ADDR_W-1:0] PC_STRIDE  = ADDR_W'(InstByteStride);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               deq, enq_ok, redirect, fetch_en;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_o = (fifo_count != '0);
    // Gated by empty, which is equivalent to gating by id_valid_o.
    deq        = ~fifo_empty & id_ready_i;
    // A full buffer can still take a new entry if the head leaves this cycle.
    enq_ok     = ~fifo_full | deq;
    redirect   = (state_q == FETCH) & branch_flag_i;
    fetch_en   = (state_q == FETCH) & enq_ok & ~branch_flag_i;

    // IDLE only lasts one cycle; it provides the enable-free cycle after reset.
    if (state_q == IDLE) state_d = FETCH;

    if (redirect) begin
      // Misaligned targets are truncated to the instruction boundary.
      pc_d = branch_target_i & ~ALIGN_MASK;
    end else if (fetch_en) begin
      pc_d = pc_q + PC_STRIDE;   // wraps modulo 2^ADDR_W
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign rom_ce   = fetch_en ? ChipEnable : ChipDisable;
  assign rom_addr = pc_q;

  // Head fields are forced to zero when the buffer is empty so stale
  // storage never leaks onto the decode interface.
  assign id_pc_o   = id_valid_o ? fifo_head[ENTRY_W-1 -: ADDR_W] : '0;
  assign id_inst_o = id_valid_o ? fifo_head[INST_W-1:0] : INST_W'(ZeroDoubleWord);

  fetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch_en),
    .push_data_i ({pc_q, rom_inst}),
    .pop_i       (deq),
    .flush_i     (redirect),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. A ROM model returns
//               64'h1000 + address. A transaction-level reference (queue of
//               buffered {pc, inst} entries plus the next fetch PC) predicts
//               every output each cycle. Directed scenarios are followed by
//               a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [63:0] rom_inst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [63:0] id_inst_o;

  always #5 clk = ~clk;

  // Combinational ROM; returns zero while disabled.
  assign rom_inst = rom_ce ? (64'h1000 + {32'h0, rom_addr}) : 64'h0;

  inst_fetch #(
    .ADDR_W     (32),
    .INST_W     (64),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce          (rom_ce),
    .rom_addr        (rom_addr),
    .rom_inst        (rom_inst),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } ent_t;

  ent_t        m_q[$];        // instructions buffered, oldest first
  logic [31:0] m_pc;          // next address to fetch
  bit          m_run   = 0;   // past the post-reset idle cycle
  bit          m_known = 0;   // a reset has been applied
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic b, input logic [31:0] t, input logic rd);
    logic        exp_valid, exp_ce, deq;
    logic [31:0] exp_pc;
    logic [63:0] exp_inst;
    ent_t        e;
    rst             = r;
    branch_flag_i   = b;
    branch_target_i = t;
    id_ready_i      = rd;
    #1;
    exp_valid = (m_q.size() != 0);
    exp_pc    = 32'h0;
    exp_inst  = 64'h0;
    if (exp_valid) begin
      exp_pc   = m_q[0].pc;
      exp_inst = m_q[0].inst;
    end
    deq    = exp_valid && rd;
    exp_ce = m_run && ((m_q.size() < DEPTH) || deq) && !b;
    if (m_known) begin
      check("id_valid", {63'h0, id_valid_o}, {63'h0, exp_valid});
      check("id_pc",    {32'h0, id_pc_o},    {32'h0, exp_pc});
      check("id_inst",  id_inst_o,           exp_inst);
      check("rom_ce",   {63'h0, rom_ce},     {63'h0, exp_ce});
      check("rom_addr", {32'h0, rom_addr},   {32'h0, m_pc});
    end
    @(posedge clk);
    if (!r) begin
      m_known = 1;
      m_run   = 0;
      m_pc    = 32'h0;
      m_q.delete();
    end else if (!m_run) begin
      m_run = 1;                       // redirects are ignored while idle
    end else if (b) begin
      m_q.delete();
      m_pc = t & ~32'h7;
    end else begin
      if (deq) void'(m_q.pop_front());
      if (exp_ce) begin
        e.pc   = m_pc;
        e.inst = 64'h1000 + {32'h0, m_pc};
        m_q.push_back(e);
        m_pc = m_pc + 32'h8;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0; id_ready_i = 1'b0;

    // Reset, then release with decode always ready.
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Decode stalls: buffer fills, then drains in order.
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect to a misaligned target while the buffer is full and ready=1.
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect while push and pop are both active.
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Address wrap at the top of the space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Mid-stream reset with a full buffer; a redirect on release is ignored.
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0500, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r, b, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 49) != 0);
      b  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 3) != 0);
      t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
      cycle(r, b, t, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
